// File: rtl/tag_stream_serializer.sv
// tag_stream_serializer
// Takes multi-lane tag beats (one tkeep bit per lane) and emits the kept tags
// one per cycle, lowest lane first, on a single-lane valid/ready output.
// It also counts emitted tags and flags any tag whose time is earlier than
// the tag emitted before it.
module tag_stream_serializer #(
  parameter int WORD_WIDTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  input  logic [WORD_WIDTH-1:0]       s_axis_tkeep,
  input  logic [WORD_WIDTH-1:0][4:0]  s_axis_channel,
  input  logic [WORD_WIDTH-1:0][63:0] s_axis_tagtime,
  input  logic [WORD_WIDTH-1:0]       s_axis_rising_edge,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic [4:0]                  m_axis_channel,
  output logic [63:0]                 m_axis_tagtime,
  output logic                        m_axis_rising_edge,
  output logic [31:0]                 tag_count,
  output logic                        order_error,
  output logic [15:0]                 order_error_count
);

  logic [WORD_WIDTH-1:0]       pending_q, pending_d;
  logic [WORD_WIDTH-1:0][4:0]  chan_q;
  logic [WORD_WIDTH-1:0][63:0] time_q;
  logic [WORD_WIDTH-1:0]       edge_q;
  logic [WORD_WIDTH-1:0]       sel_oh;
  logic                        last_one;
  logic                        s_hs, m_hs;

  logic [31:0] tag_count_q;
  logic        order_error_q;
  logic [15:0] err_count_q;
  logic [63:0] last_time_q;
  logic        ref_valid_q;

  // Lowest set bit of the pending mask picks the lane currently presented.
  // The last-tag flag lets a new beat load on the same edge as the final emit.
  always_comb begin
    sel_oh   = pending_q & (~pending_q + WORD_WIDTH'(1));
    last_one = (|pending_q) && (pending_q == sel_oh);
  end

  assign m_axis_tvalid = |pending_q;
  assign s_axis_tready = rst & (~(|pending_q) | (last_one & m_axis_tready));
  assign s_hs          = s_axis_tvalid & s_axis_tready;
  assign m_hs          = m_axis_tvalid & m_axis_tready;

  // Output mux: OR of the selected lane; all-zero when nothing is pending.
  always_comb begin
    m_axis_channel     = '0;
    m_axis_tagtime     = '0;
    m_axis_rising_edge = 1'b0;
    for (int i = 0; i < WORD_WIDTH; i++) begin
      if (sel_oh[i]) begin
        m_axis_channel     = m_axis_channel | chan_q[i];
        m_axis_tagtime     = m_axis_tagtime | time_q[i];
        m_axis_rising_edge = m_axis_rising_edge | edge_q[i];
      end
    end
  end

  // Pending mask next state: a fresh beat overrides the emitted-bit clear.
  always_comb begin
    pending_d = pending_q;
    if (m_hs) pending_d = pending_q & ~sel_oh;
    if (s_hs) pending_d = s_axis_tkeep;
  end

  // One-beat holding buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending_q <= '0;
      chan_q    <= '0;
      time_q    <= '0;
      edge_q    <= '0;
    end else begin
      pending_q <= pending_d;
      if (s_hs) begin
        chan_q <= s_axis_channel;
        time_q <= s_axis_tagtime;
        edge_q <= s_axis_rising_edge;
      end
    end
  end

  // Status: tag counter and time-order checker; clear beats a coincident emit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_count_q   <= '0;
      order_error_q <= 1'b0;
      err_count_q   <= '0;
      last_time_q   <= '0;
      ref_valid_q   <= 1'b0;
    end else if (clear) begin
      tag_count_q   <= '0;
      order_error_q <= 1'b0;
      err_count_q   <= '0;
      ref_valid_q   <= 1'b0;
    end else if (m_hs) begin
      tag_count_q <= tag_count_q + 32'd1;
      if (ref_valid_q && (m_axis_tagtime < last_time_q)) begin
        order_error_q <= 1'b1;
        if (err_count_q != 16'hFFFF) err_count_q <= err_count_q + 16'd1;
      end
      last_time_q <= m_axis_tagtime;
      ref_valid_q <= 1'b1;
    end
  end

  assign tag_count         = tag_count_q;
  assign order_error       = order_error_q;
  assign order_error_count = err_count_q;

endmodule
